// File: rtl/usc_pkg.sv
// Shared mode encodings for the universal shift/count register.
package usc_pkg;

    localparam logic [2:0] USC_HOLD = 3'b000;
    localparam logic [2:0] USC_LOAD = 3'b001;
    localparam logic [2:0] USC_SHL  = 3'b010;
    localparam logic [2:0] USC_SHR  = 3'b011;
    localparam logic [2:0] USC_ROTL = 3'b100;
    localparam logic [2:0] USC_ROTR = 3'b101;
    localparam logic [2:0] USC_UP   = 3'b110;
    localparam logic [2:0] USC_DOWN = 3'b111;

endpackage

// File: rtl/usc_next.sv
// Combinational next-state, serial-out and terminal-count logic for universal_shift_counter.
module usc_next
    import usc_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 2 ** WIDTH
) (
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             sout,
    output logic [WIDTH-1:0] q_next,
    output logic             sout_next,
    output logic             tc
);

    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0] MAX_W = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH:0] q_ext;
    assign q_ext = {1'b0, q};

    always_comb begin
        q_next    = q;
        sout_next = sout;
        tc        = 1'b0;
        if (en) begin
            unique case (mode)
                USC_HOLD: q_next = q;
                USC_LOAD: q_next = d;
                USC_SHL: begin
                    q_next    = {q[WIDTH-2:0], sin_r};
                    sout_next = q[WIDTH-1];
                end
                USC_SHR: begin
                    q_next    = {sin_l, q[WIDTH-1:1]};
                    sout_next = q[0];
                end
                USC_ROTL: begin
                    q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
                    sout_next = q[WIDTH-1];
                end
                USC_ROTR: begin
                    q_next    = {q[0], q[WIDTH-1:1]};
                    sout_next = q[0];
                end
                USC_UP: begin
                    q_next = (q_ext >= MAX_W) ? '0 : WIDTH'(q_ext + 1'b1);
                    tc     = (q_ext == MAX_W);
                end
                USC_DOWN: begin
                    // Out-of-range values recover straight to the top of the count.
                    q_next = (q_ext == '0 || q_ext >= MOD_W) ? MAX_W[WIDTH-1:0]
                                                              : WIDTH'(q_ext - 1'b1);
                    tc     = (q_ext == '0);
                end
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_counter.sv
// WIDTH-bit register with hold/load/shift/rotate/modulo-count modes and async active-low clear.
module universal_shift_counter #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULUS   = 2 ** WIDTH,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tc,
    output logic             zero
);

    logic [WIDTH-1:0] q_next;
    logic             sout_next;

    usc_next #(
        .WIDTH  (WIDTH),
        .MODULUS(MODULUS)
    ) u_next (
        .en       (en),
        .mode     (mode),
        .q        (q),
        .d        (d),
        .sin_r    (sin_r),
        .sin_l    (sin_l),
        .sout     (sout),
        .q_next   (q_next),
        .sout_next(sout_next),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q    <= WIDTH'(RESET_VAL);
            sout <= 1'b0;
        end else begin
            q    <= q_next;
            sout <= sout_next;
        end
    end

    assign zero = (q == '0);

endmodule

// File: tb/tb_universal_shift_counter.sv
// Self-checking bench: directed scenarios plus randomized ops against an arithmetic model.
module tb_universal_shift_counter;
    import usc_pkg::*;

    logic       clk = 1'b0;
    logic       clr, en, sin_r, sin_l;
    logic [2:0] mode;
    logic [3:0] d, q;
    logic       sout, tc, zero;

    logic       clr8, en8, sin_r8, sin_l8;
    logic [2:0] mode8;
    logic [7:0] d8, q8;
    logic       sout8, tc8, zero8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    universal_shift_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut (
        .clk(clk), .clr(clr), .en(en), .mode(mode), .d(d), .sin_r(sin_r), .sin_l(sin_l),
        .q(q), .sout(sout), .tc(tc), .zero(zero)
    );

    universal_shift_counter #(.WIDTH(8), .MODULUS(256), .RESET_VAL(255)) dut8 (
        .clk(clk), .clr(clr8), .en(en8), .mode(mode8), .d(d8), .sin_r(sin_r8), .sin_l(sin_l8),
        .q(q8), .sout(sout8), .tc(tc8), .zero(zero8)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: register treated as an integer in [0, 2**w).
    function automatic void model_step(input int unsigned w, input int unsigned m,
                                       input logic e, input logic [2:0] md,
                                       input int unsigned dd, input bit sr, input bit sl,
                                       inout int unsigned mq, inout bit ms);
        int unsigned p    = 1 << w;
        int unsigned half = p / 2;
        if (!e) return;
        case (md)
            USC_LOAD: mq = dd;
            USC_SHL:  begin ms = (mq >= half); mq = (mq * 2 + sr) % p; end
            USC_SHR:  begin ms = mq[0]; mq = mq / 2 + (sl ? half : 0); end
            USC_ROTL: begin ms = (mq >= half); mq = (mq * 2) % p + ((mq >= half) ? 1 : 0); end
            USC_ROTR: begin ms = mq[0]; mq = mq / 2 + (mq[0] ? half : 0); end
            USC_UP:   mq = (mq < m) ? (mq + 1) % m : 0;
            USC_DOWN: mq = (mq == 0 || mq >= m) ? m - 1 : mq - 1;
            default:  ;
        endcase
    endfunction

    function automatic bit model_tc(input int unsigned m, input logic e, input logic [2:0] md,
                                    input int unsigned mq);
        return e && ((md == USC_UP && mq == m - 1) || (md == USC_DOWN && mq == 0));
    endfunction

    task automatic drive(input logic e, input logic [2:0] md, input logic [3:0] dd,
                         input logic sr, input logic sl);
        en = e; mode = md; d = dd; sin_r = sr; sin_l = sl;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b0; drive(1'b0, USC_HOLD, 4'h0, 1'b0, 1'b0);
        clr8 = 1'b0; en8 = 1'b0; mode8 = USC_HOLD; d8 = 8'h00; sin_r8 = 1'b0; sin_l8 = 1'b0;
        tick();
        total_cnt++; if (q !== 4'h0) $display("FAIL reset_q: got %h want 0", q); else pass_cnt++;
        total_cnt++; if (sout !== 1'b0) $display("FAIL reset_sout: got %b want 0", sout);
        else pass_cnt++;
        total_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", zero);
        else pass_cnt++;
        clr = 1'b1;
        drive(1'b1, USC_LOAD, 4'h8, 1'b0, 1'b0); tick();
        drive(1'b1, USC_SHL, 4'h0, 1'b0, 1'b0); tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, USC_UP, 4'h0, 1'b0, 1'b0); tick();
        end
        total_cnt++; if (q !== 4'h7 || sout !== 1'b1)
            $display("FAIL pre_clr: got q=%h sout=%b want q=7 sout=1", q, sout);
        else pass_cnt++;
        clr = 1'b0; #1;
        total_cnt++; if (q !== 4'h0 || sout !== 1'b0)
            $display("FAIL async_clr: got q=%h sout=%b want q=0 sout=0", q, sout);
        else pass_cnt++;
        clr = 1'b1;
        drive(1'b1, USC_HOLD, 4'h0, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'h0) $display("FAIL hold_after_clr: got %h want 0", q);
        else pass_cnt++;
    endtask

    task automatic test_shift();
        logic [3:0] exp_q [3]  = '{4'h7, 4'hF, 4'h7};
        logic       exp_s [3]  = '{1'b1, 1'b0, 1'b1};
        logic [2:0] ops   [3]  = '{USC_SHL, USC_SHL, USC_SHR};
        drive(1'b1, USC_LOAD, 4'hB, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'hB) $display("FAIL load_B: got %h want b", q); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ops[i], 4'h0, 1'b1, 1'b0); tick();
            total_cnt++; if (q !== exp_q[i] || sout !== exp_s[i])
                $display("FAIL shift_%0d: got q=%h sout=%b want q=%h sout=%b",
                         i, q, sout, exp_q[i], exp_s[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_rotate();
        drive(1'b1, USC_LOAD, 4'b1001, 1'b0, 1'b0); tick();
        drive(1'b1, USC_ROTL, 4'h0, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'b0011 || sout !== 1'b1)
            $display("FAIL rotl: got q=%b sout=%b want 0011/1", q, sout);
        else pass_cnt++;
        drive(1'b1, USC_ROTR, 4'h0, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'b1001 || sout !== 1'b1)
            $display("FAIL rotr: got q=%b sout=%b want 1001/1", q, sout);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, USC_ROTL, 4'h0, 1'b0, 1'b0); tick();
        end
        total_cnt++; if (q !== 4'b1001) $display("FAIL rotl_x4: got %b want 1001", q);
        else pass_cnt++;
    endtask

    task automatic test_count();
        drive(1'b1, USC_LOAD, 4'h0, 1'b0, 1'b0); tick();
        for (int i = 1; i <= 11; i++) begin
            int unsigned prev = (i == 1) ? 0 : (i - 1) % 10;
            drive(1'b1, USC_UP, 4'h0, 1'b0, 1'b0);
            total_cnt++; if (tc !== (prev == 9))
                $display("FAIL up_tc_%0d: got %b want %b", i, tc, prev == 9);
            else pass_cnt++;
            tick();
            total_cnt++; if (q !== 4'(i % 10))
                $display("FAIL up_q_%0d: got %h want %h", i, q, i % 10);
            else pass_cnt++;
        end
        drive(1'b1, USC_LOAD, 4'h0, 1'b0, 1'b0); tick();
        drive(1'b1, USC_DOWN, 4'h0, 1'b0, 1'b0);
        total_cnt++; if (tc !== 1'b1) $display("FAIL down_tc: got %b want 1", tc);
        else pass_cnt++;
        tick();
        total_cnt++; if (q !== 4'h9) $display("FAIL down_wrap: got %h want 9", q);
        else pass_cnt++;
    endtask

    task automatic test_range_enable();
        drive(1'b1, USC_LOAD, 4'hE, 1'b0, 1'b0); tick();
        drive(1'b1, USC_UP, 4'h0, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'h0) $display("FAIL oor_up: got %h want 0", q); else pass_cnt++;
        drive(1'b1, USC_LOAD, 4'hE, 1'b0, 1'b0); tick();
        drive(1'b1, USC_DOWN, 4'h0, 1'b0, 1'b0); tick();
        total_cnt++; if (q !== 4'h9) $display("FAIL oor_down: got %h want 9", q);
        else pass_cnt++;
        drive(1'b1, USC_SHL, 4'h0, 1'b0, 1'b0); tick();  // q=2, sout=1
        for (int md = 0; md < 8; md++) begin
            drive(1'b0, 3'(md), 4'h5, 1'b1, 1'b1);
            total_cnt++; if (tc !== 1'b0) $display("FAIL en0_tc_m%0d: got %b want 0", md, tc);
            else pass_cnt++;
            tick();
            total_cnt++; if (q !== 4'h2 || sout !== 1'b1)
                $display("FAIL en0_hold_m%0d: got q=%h sout=%b want 2/1", md, q, sout);
            else pass_cnt++;
        end
        drive(1'b0, USC_UP, 4'h0, 1'b0, 1'b0);
        drive(1'b1, USC_LOAD, 4'h9, 1'b0, 1'b0); tick();
        drive(1'b0, USC_UP, 4'h0, 1'b0, 1'b0);
        total_cnt++; if (tc !== 1'b0) $display("FAIL en0_tc_at9: got %b want 0", tc);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int unsigned mq = 0;
        bit          ms = 1'b0;
        clr = 1'b0; #1; clr = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic       e  = ($urandom_range(0, 7) != 0);
            logic [2:0] md = 3'($urandom_range(0, 7));
            logic [3:0] dd = 4'($urandom);
            bit         sr = 1'($urandom);
            bit         sl = 1'($urandom);
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b0; #1;
                mq = 0; ms = 1'b0;
                total_cnt++; if (q !== 4'h0 || sout !== 1'b0)
                    $display("FAIL rand_clr_%0d: got q=%h sout=%b want 0/0", i, q, sout);
                else pass_cnt++;
                clr = 1'b1;
            end
            drive(e, md, dd, sr, sl);
            total_cnt++; if (tc !== model_tc(10, e, md, mq))
                $display("FAIL rand_tc_%0d: got %b want %b", i, tc, model_tc(10, e, md, mq));
            else pass_cnt++;
            model_step(4, 10, e, md, dd, sr, sl, mq, ms);
            tick();
            total_cnt++; if (q !== 4'(mq) || sout !== ms || zero !== (mq == 0))
                $display("FAIL rand_q_%0d: got q=%h sout=%b zero=%b want q=%h sout=%b zero=%b",
                         i, q, sout, zero, mq, ms, mq == 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_wide();
        clr8 = 1'b1; en8 = 1'b0; mode8 = USC_HOLD; tick();
        total_cnt++; if (q8 !== 8'hFF || zero8 !== 1'b0)
            $display("FAIL w8_reset: got q=%h zero=%b want ff/0", q8, zero8);
        else pass_cnt++;
        en8 = 1'b1; mode8 = USC_UP; #1;
        total_cnt++; if (tc8 !== 1'b1) $display("FAIL w8_tc: got %b want 1", tc8);
        else pass_cnt++;
        tick();
        total_cnt++; if (q8 !== 8'h00 || zero8 !== 1'b1)
            $display("FAIL w8_wrap: got q=%h zero=%b want 00/1", q8, zero8);
        else pass_cnt++;
        mode8 = USC_DOWN; tick();
        total_cnt++; if (q8 !== 8'hFF) $display("FAIL w8_down: got %h want ff", q8);
        else pass_cnt++;
        en8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_shift();
        test_rotate();
        test_count();
        test_range_enable();
        test_random();
        test_wide();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
